// File: rtl/spi_pkg.sv
// Shared widths, defaults and reset constants for the SPI slave front-end.
package spi_pkg;

  localparam int unsigned SPI_BYTE_W   = 8;
  localparam int unsigned SPI_CNT_W    = 3;
  localparam int unsigned SPI_SYNC_DEF = 2;

  localparam logic                  SPI_CS_IDLE  = 1'b1;
  localparam logic [SPI_BYTE_W-1:0] SPI_DATA_RST = 8'h00;

  typedef logic [SPI_BYTE_W-1:0] spi_byte_t;
  typedef logic [SPI_CNT_W-1:0]  spi_cnt_t;

endpackage

// File: rtl/sync_ff.sv
// N-stage flip-flop synchroniser with a configurable reset level.
module sync_ff #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ff <= {STAGES{RST_VAL}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_bridge.sv
// SPI mode-0 slave front-end: synchronises the pins into clk, deserialises
// MOSI into bytes for the decoder and serialises decoder bytes onto MISO.
module spi_bridge
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SPI_SYNC_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_en,
  output logic                  byte_sync,
  output logic [SPI_BYTE_W-1:0] data_in,
  input  logic [SPI_BYTE_W-1:0] data_out,
  output logic                  frame_start
);

  logic sclk_s, cs_s, mosi_s;
  logic sclk_h, cs_h;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise, selected;

  spi_cnt_t  bit_cnt;
  spi_byte_t tx_sr;
  logic      load_dly;
  // Only seven bits are kept; the eighth comes straight from mosi_s on completion.
  logic [SPI_BYTE_W-2:0] rx_sr;

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(SPI_CS_IDLE)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_h <= 1'b0;
      cs_h   <= SPI_CS_IDLE;
    end else begin
      sclk_h <= sclk_s;
      cs_h   <= cs_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_h;
  assign sclk_fall = ~sclk_s & sclk_h;
  assign cs_fall   = ~cs_s & cs_h;
  assign cs_rise   = cs_s & ~cs_h;
  assign selected  = ~cs_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      load_dly    <= 1'b0;
      byte_sync   <= 1'b0;
      frame_start <= 1'b0;
      miso_en     <= 1'b0;
      data_in     <= SPI_DATA_RST;
    end else begin
      byte_sync   <= 1'b0;
      frame_start <= cs_fall;
      load_dly    <= byte_sync;
      if (cs_fall) begin
        bit_cnt  <= '0;
        tx_sr    <= data_out;
        miso_en  <= 1'b1;
        load_dly <= 1'b0;
      end else if (cs_rise) begin
        bit_cnt  <= '0;
        miso_en  <= 1'b0;
        load_dly <= 1'b0;
      end else if (selected) begin
        if (sclk_rise) begin
          rx_sr   <= {rx_sr[SPI_BYTE_W-3:0], mosi_s};
          bit_cnt <= bit_cnt + spi_cnt_t'(1);
          if (bit_cnt == '1) begin
            byte_sync <= 1'b1;
            data_in   <= {rx_sr, mosi_s};
          end
        end
        // Reload wins over a shift; the clock ratio keeps them apart anyway.
        if (load_dly) begin
          tx_sr <= data_out;
        end else if (sclk_fall && bit_cnt != '0) begin
          tx_sr <= {tx_sr[SPI_BYTE_W-2:0], 1'b0};
        end
      end
    end
  end

  assign miso = miso_en & tx_sr[SPI_BYTE_W-1];

endmodule

// File: tb/tb_spi_bridge.sv
// Bench for spi_bridge: two instances (2- and 3-stage sync) driven by one SPI master.
module tb_spi_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;

  logic       miso[2];
  logic       miso_en[2];
  logic       byte_sync[2];
  logic       frame_start[2];
  logic [7:0] data_in[2];
  logic [7:0] data_out[2];

  always #5 clk = ~clk;

  spi_bridge #(.SYNC_STAGES(2)) dut_s2 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso[0]), .miso_en(miso_en[0]), .byte_sync(byte_sync[0]),
    .data_in(data_in[0]), .data_out(data_out[0]), .frame_start(frame_start[0])
  );

  spi_bridge #(.SYNC_STAGES(3)) dut_s3 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso[1]), .miso_en(miso_en[1]), .byte_sync(byte_sync[1]),
    .data_in(data_in[1]), .data_out(data_out[1]), .frame_start(frame_start[1])
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: bytes the master sends / expects on MISO, and completed bytes in order.
  logic [7:0]  rx_arr[16];
  logic [7:0]  tx_arr[16];
  logic [7:0]  exp_arr[256];
  int          exp_cyc[256];
  int unsigned exp_wr = 0;
  int unsigned frame_base = 0;
  logic [7:0]  last_rx = 8'h00;

  int unsigned rd[2] = '{0, 0};
  int unsigned fs_cnt[2] = '{0, 0};
  logic        bs_prev[2] = '{1'b0, 1'b0};
  logic        fs_prev[2] = '{1'b0, 1'b0};
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Decoder stand-in: byte k of the frame is presented after the k-th byte_sync.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      data_out[i] = tx_arr[4'(rd[i] - frame_base)];
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (byte_sync[i]) begin
        check($sformatf("bs_width%0d", i), 32'(bs_prev[i]), 32'd0);
        if (rd[i] < exp_wr) begin
          check($sformatf("data_in%0d_n%0d", i, rd[i]), 32'(data_in[i]), 32'(exp_arr[rd[i]]));
          check($sformatf("bs_latency%0d_n%0d", i, rd[i]), 32'(cyc - exp_cyc[rd[i]]), 32'(3 + i));
        end else begin
          check($sformatf("bs_extra%0d", i), rd[i] + 1, exp_wr);
        end
        rd[i] <= rd[i] + 1;
      end
      if (frame_start[i]) begin
        check($sformatf("fs_width%0d", i), 32'(fs_prev[i]), 32'd0);
        fs_cnt[i] <= fs_cnt[i] + 1;
      end
      bs_prev[i] <= byte_sync[i];
      fs_prev[i] <= frame_start[i];
    end
  end

  task automatic randomize_tables();
    for (int k = 0; k < 16; k++) begin
      rx_arr[k] = 8'($urandom);
      tx_arr[k] = 8'($urandom);
    end
  endtask

  task automatic check_idle(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_bs%0d", tag, i), 32'(byte_sync[i]), 32'd0);
      check($sformatf("%s_miso_en%0d", tag, i), 32'(miso_en[i]), 32'd0);
      check($sformatf("%s_miso%0d", tag, i), 32'(miso[i]), 32'd0);
      check($sformatf("%s_data_in%0d", tag, i), 32'(data_in[i]), 32'(last_rx));
    end
  endtask

  // Master transfer of nbits bits, MSB first; sclk half period in clk cycles.
  task automatic run_frame(input int nbits, input int half);
    int unsigned fs0[2];
    int k;
    int bi;
    frame_base = exp_wr;
    fs0[0] = fs_cnt[0];
    fs0[1] = fs_cnt[1];
    @(negedge clk);
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      k  = b / 8;
      bi = 7 - (b % 8);
      mosi = rx_arr[k][bi];
      repeat (half) @(negedge clk);
      sclk = 1'b1;
      for (int i = 0; i < 2; i++) begin
        check($sformatf("miso%0d_bit%0d", i, b), 32'(miso[i]), 32'(tx_arr[k][bi]));
        check($sformatf("miso_en%0d_bit%0d", i, b), 32'(miso_en[i]), 32'd1);
      end
      if (b % 8 == 7) begin
        exp_arr[exp_wr] = rx_arr[k];
        exp_cyc[exp_wr] = cyc;
        exp_wr++;
        last_rx = rx_arr[k];
      end
      repeat (half) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (half) @(negedge clk);
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (12) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rx_count%0d", i), rd[i], exp_wr);
      check($sformatf("fs_count%0d", i), fs_cnt[i] - fs0[i], 32'd1);
    end
    check_idle("post_frame");
  endtask

  task automatic reset_pulse(input int n);
    rst_n = 1'b0;
    cs_n  = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      sclk = 1'($urandom);
      mosi = 1'($urandom);
      last_rx = 8'h00;
      if (c > 0) check_idle($sformatf("in_reset%0d", c));
    end
    @(negedge clk);
    check_idle("reset_last");
    sclk  = 1'b0;
    mosi  = 1'b0;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_idle("after_reset");
  endtask

  initial begin
    randomize_tables();
    reset_pulse(4);

    // Two-byte write with read-back at 10:1.
    randomize_tables();
    rx_arr[0] = 8'h85; rx_arr[1] = 8'hA5;
    tx_arr[0] = 8'h3C; tx_arr[1] = 8'hC3;
    run_frame(16, 5);

    // Abort after 5 bits, then a clean byte.
    randomize_tables();
    rx_arr[0] = 8'hFF;
    run_frame(5, 5);
    randomize_tables();
    rx_arr[0] = 8'h12;
    run_frame(8, 5);

    // Reset in the middle of a byte, then a fresh frame.
    frame_base = exp_wr;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      mosi = 1'($urandom);
      repeat (5) @(negedge clk);
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
    end
    reset_pulse(3);
    randomize_tables();
    rx_arr[0] = 8'h5A;
    run_frame(8, 5);

    // Minimum ratio 8:1, decoder echoes each received byte.
    randomize_tables();
    rx_arr[0] = 8'h00; rx_arr[1] = 8'hFF; rx_arr[2] = 8'h55;
    tx_arr[1] = 8'h00; tx_arr[2] = 8'hFF; tx_arr[3] = 8'h55;
    run_frame(24, 4);

    // Random frames, some with a trailing partial byte.
    for (int f = 0; f < 8; f++) begin
      randomize_tables();
      run_frame(int'($urandom_range(1, 4)) * 8 + int'($urandom_range(0, 1)) * int'($urandom_range(1, 7)),
                int'($urandom_range(4, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/spi_bridge.md
Name: spi_bridge

Overview:
- Upstream SPI slave front-end for the PWM generator's register path.
- Synchronises the external SPI pins (mode 0, MSB first) into the `clk` domain and deserialises MOSI into bytes.
- Presents each byte to the instruction decoder as `data_in` with a one-cycle `byte_sync` pulse.
- Serialises the decoder's `data_out` back onto MISO.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on `sclk`, `cs_n` and `mosi` before edge detection (legal range 2..3).

Ports:
- clk  in  1  peripheral clock.
- rst_n  in  1  reset; synchronous, active-low. The only clock is `clk`.
- sclk  in  1  SPI clock from the master; idles low (CPOL=0).
- cs_n  in  1  SPI chip select, active-low.
- mosi  in  1  serial data from the master.
- miso  out  1  serial data to the master.
- miso_en  out  1  MISO output enable (pad tristate control); high while selected.
- byte_sync  out  1  one-cycle pulse when a full byte has been received.
- data_in  out  8  last received byte; updated together with `byte_sync`.
- data_out  in  8  byte from the decoder to transmit next.
- frame_start  out  1  one-cycle pulse on detected `cs_n` assertion; lets the decoder resynchronise its phase.

Behaviour:
- Reset (`rst_n` low at a `clk` rising edge): all synchroniser flops cleared; `sclk`/`mosi` stages to 0, `cs_n` stages to 1.
  - Outputs: `byte_sync`=0, `frame_start`=0, `data_in`=8'h00, `miso`=0, `miso_en`=0.
  - Internal: `bit_cnt`=0, `rx_sr`=0, `tx_sr`=0, `load_dly`=0.
  - Reset mid-byte discards all partial state; no pulse is emitted.
- Synchronisation: `sclk`, `cs_n`, `mosi` each pass through SYNC_STAGES flops, then one history flop for edge detect.
  - rise = sync & ~hist; fall = ~sync & hist.
  - `mosi` uses the same depth as `sclk`, so it is sampled in alignment with the detected `sclk` edge.
- Clock ratio: f_clk >= 8 x f_sclk. Below this ratio, behaviour is undefined.
- Select:
  - `cs_n` fall detected: `frame_start`=1 for one cycle; `bit_cnt`<=0; `tx_sr`<=`data_out`; `miso_en`<=1.
  - `cs_n` rise detected: `miso_en`<=0, `miso`<=0, `bit_cnt`<=0. A partial byte is dropped and no `byte_sync` is emitted.
- Receive: on an `sclk` rise while selected, `rx_sr`<={`rx_sr`[6:0], `mosi_s`}; `bit_cnt`<=`bit_cnt`+1 (3-bit, wraps 7->0).
- Byte complete: the rise with `bit_cnt`==7.
  - Next cycle: `byte_sync`=1 and `data_in`={`rx_sr`[6:0], `mosi_s`}.
  - `data_in` holds until the next completed byte.
- Transmit:
  - `miso` = `tx_sr`[7] whenever selected.
  - On an `sclk` fall with `bit_cnt`!=0: `tx_sr`<=`tx_sr`<<1.
  - On an `sclk` fall with `bit_cnt`==0 (byte boundary): `tx_sr` is not shifted.
- Reload: `load_dly` is set the cycle `byte_sync` is high. The following cycle, `tx_sr`<=`data_out`. This picks up decoder data registered on the `byte_sync` edge.
  - Latency: 8th rise detected at T, `byte_sync` at T+1, `tx_sr` reload at T+2.
  - The reload therefore precedes the next `sclk` fall by the ratio rule.
- Simultaneous events: a `cs_n` rise in the same cycle as an `sclk` rise takes priority; no shift and no `byte_sync`.
- `sclk` edges while deselected are ignored.
- A `cs_n` fall in the same cycle as a pending reload takes priority; `tx_sr` loads from `data_out` either way.

Decomposition:
- Shared package `spi_pkg`:
  - SPI_BYTE_W=8.
  - SPI_CNT_W=3.
  - SPI_SYNC_DEF=2.
  - Reset constants for the `cs_n` idle level (1) and `data_in` (8'h00).
- One sub-module: `sync_ff`, a parameterised N-stage synchroniser with a reset value parameter. It is instantiated three times (`sclk`, `cs_n`, `mosi`).

Test Plan:
- Reset: hold `rst_n`=0 for 3 clk with `sclk`/`mosi` toggling -> `byte_sync`=0, `data_in`=8'h00, `miso_en`=0, `miso`=0 throughout; no pulse after release.
- Single write frame (clk:sclk = 10:1): `cs_n` low, shift 8'h85 then 8'hA5, `cs_n` high -> `frame_start` one pulse; `byte_sync` pulses twice, with `data_in`=8'h85 then 8'hA5; each pulse exactly one cycle, one cycle after the 8th detected rise.
- Read-back: `data_out`=8'h3C before `cs_n` falls, then `data_out`=8'hC3 driven in the cycle after the first `byte_sync` -> master samples 8'h3C on byte 0 and 8'hC3 on byte 1, MSB first, on `sclk` rises.
- Abort: `cs_n` rises after 5 bits of 8'hFF -> no `byte_sync`, `data_in` unchanged, `miso_en`=0. The next frame sending 8'h12 yields `data_in`=8'h12.
- Reset mid-frame: `rst_n` low after 4 bits, released, new frame sends 8'h5A -> `data_in`=8'h5A, no stale bits.
- Minimum ratio (clk:sclk = 8:1) with SYNC_STAGES=3, back-to-back bytes 8'h00, 8'hFF, 8'h55 and `data_out` echoing the byte received -> all three received correctly; MISO byte 1 = 8'h00, byte 2 = 8'hFF.
